// File: rtl/led_pattern_gen.sv
// LED pattern generator: synchronised buttons pick one of four pattern modes and
// an output colour; a switch-selected prescaler paces the pattern updates.
module led_pattern_gen #(
  parameter int N_LEDS   = 8,
  parameter int NB_SEL   = 2,
  parameter int NB_COUNT = 14,
  parameter int NB_SW    = 4,
  parameter int NB_BTN   = 4,
  parameter int LIMIT_0  = 15,
  parameter int LIMIT_1  = 63,
  parameter int LIMIT_2  = 255,
  parameter int LIMIT_3  = 1023
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic [NB_SW-1:0]  i_sw,
  input  logic [NB_BTN-1:0] i_btn,
  output logic [N_LEDS-1:0] o_led,
  output logic [N_LEDS-1:0] o_led_r,
  output logic [N_LEDS-1:0] o_led_g,
  output logic [N_LEDS-1:0] o_led_b,
  output logic [1:0]        o_mode,
  output logic              o_tick
);

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'd0,
    MODE_FLASH  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_FILL   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    COL_RED   = 2'd0,
    COL_GREEN = 2'd1,
    COL_BLUE  = 2'd2
  } colour_e;

  localparam int                DIR_BIT  = NB_SEL + 1;
  localparam logic [N_LEDS-1:0] ALL_ONES = '1;
  localparam logic [N_LEDS-1:0] ONE_HOT0 = N_LEDS'(1);

  logic [NB_BTN-1:0] btn_s1_q, btn_s2_q, btn_prev_q, btn_evt;

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      btn_prev_q <= '0;
    end else begin
      btn_s1_q   <= i_btn;
      btn_s2_q   <= btn_s1_q;
      btn_prev_q <= btn_s2_q;
    end
  end

  assign btn_evt = btn_s2_q & ~btn_prev_q;

  logic              enable, dir_sw, mode_adv;
  logic [NB_SEL-1:0] speed_sel;

  assign enable    = i_sw[0];
  assign speed_sel = i_sw[NB_SEL:1];
  assign dir_sw    = i_sw[DIR_BIT];
  assign mode_adv  = btn_evt[0];

  logic [NB_COUNT-1:0] limit, count_q, count_d;
  logic                tick_raw, tick;

  always_comb begin
    limit = NB_COUNT'(LIMIT_0);
    case (speed_sel)
      NB_SEL'(1): limit = NB_COUNT'(LIMIT_1);
      NB_SEL'(2): limit = NB_COUNT'(LIMIT_2);
      NB_SEL'(3): limit = NB_COUNT'(LIMIT_3);
      default:    limit = NB_COUNT'(LIMIT_0);
    endcase
  end

  // >= rather than == so that lowering the limit mid-count still terminates
  assign tick_raw = enable && (count_q >= limit);
  assign tick     = tick_raw && !mode_adv;

  always_comb begin
    count_d = count_q + NB_COUNT'(1);
    if (!enable || mode_adv || tick_raw) count_d = '0;
  end

  mode_e mode_q, mode_d;

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) mode_q <= MODE_SHIFT;
    else         mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    if (mode_adv) begin
      case (mode_q)
        MODE_SHIFT:  mode_d = MODE_FLASH;
        MODE_FLASH:  mode_d = MODE_BOUNCE;
        MODE_BOUNCE: mode_d = MODE_FILL;
        MODE_FILL:   mode_d = MODE_SHIFT;
        default:     mode_d = MODE_SHIFT;
      endcase
    end
  end

  logic [N_LEDS-1:0] pattern_q, pattern_d, pattern_step;
  logic              dir_up_q, dir_up_d;

  always_comb begin
    pattern_step = pattern_q;
    case (mode_q)
      MODE_SHIFT:
        pattern_step = dir_sw ? {pattern_q[0], pattern_q[N_LEDS-1:1]}
                              : {pattern_q[N_LEDS-2:0], pattern_q[N_LEDS-1]};
      MODE_FLASH:
        pattern_step = ~pattern_q;
      MODE_BOUNCE:
        pattern_step = dir_up_q ? (pattern_q << 1) : (pattern_q >> 1);
      MODE_FILL:
        if (pattern_q == ALL_ONES) pattern_step = '0;
        else if (dir_sw)           pattern_step = {1'b1, pattern_q[N_LEDS-1:1]};
        else                       pattern_step = {pattern_q[N_LEDS-2:0], 1'b1};
      default:
        pattern_step = pattern_q;
    endcase
  end

  // A mode change reloads the entry pattern even while disabled.
  always_comb begin
    pattern_d = pattern_q;
    dir_up_d  = dir_up_q;
    if (mode_adv) begin
      dir_up_d = 1'b1;
      case (mode_d)
        MODE_SHIFT:  pattern_d = ONE_HOT0;
        MODE_FLASH:  pattern_d = ALL_ONES;
        MODE_BOUNCE: pattern_d = ONE_HOT0;
        MODE_FILL:   pattern_d = '0;
        default:     pattern_d = ONE_HOT0;
      endcase
    end else if (tick) begin
      pattern_d = pattern_step;
      if (mode_q == MODE_BOUNCE) begin
        if (pattern_step[N_LEDS-1]) dir_up_d = 1'b0;
        else if (pattern_step[0])   dir_up_d = 1'b1;
      end
    end
  end

  colour_e colour_q, colour_d;

  always_comb begin
    colour_d = colour_q;
    if (btn_evt[1])      colour_d = COL_RED;
    else if (btn_evt[2]) colour_d = COL_GREEN;
    else if (btn_evt[3]) colour_d = COL_BLUE;
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      count_q   <= '0;
      pattern_q <= ONE_HOT0;
      dir_up_q  <= 1'b1;
      colour_q  <= COL_RED;
    end else begin
      count_q   <= count_d;
      pattern_q <= pattern_d;
      dir_up_q  <= dir_up_d;
      colour_q  <= colour_d;
    end
  end

  logic [N_LEDS-1:0] led_gated;

  // Outputs are gated by reset directly so they drop without waiting for an edge.
  always_comb begin
    o_mode    = mode_q;
    o_tick    = tick && !i_reset;
    led_gated = (enable && !i_reset) ? pattern_q : '0;
    o_led     = led_gated;
    o_led_r   = (colour_q == COL_RED)   ? led_gated : '0;
    o_led_g   = (colour_q == COL_GREEN) ? led_gated : '0;
    o_led_b   = (colour_q == COL_BLUE)  ? led_gated : '0;
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen (4 LEDs): directed scenarios plus random switch and
// button activity, compared every cycle against a behavioural model.
module tb_led_pattern_gen;

  localparam int N    = 4;
  localparam int MASK = (1 << N) - 1;

  logic         clock = 1'b0;
  logic         i_reset;
  logic [3:0]   i_sw;
  logic [3:0]   i_btn;
  logic [N-1:0] o_led, o_led_r, o_led_g, o_led_b;
  logic [1:0]   o_mode;
  logic         o_tick;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clock = ~clock;

  led_pattern_gen #(.N_LEDS(N)) dut (
    .clock   (clock),
    .i_reset (i_reset),
    .i_sw    (i_sw),
    .i_btn   (i_btn),
    .o_led   (o_led),
    .o_led_r (o_led_r),
    .o_led_g (o_led_g),
    .o_led_b (o_led_b),
    .o_mode  (o_mode),
    .o_tick  (o_tick)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lim_of(input logic [1:0] s);
    case (s)
      2'd0:    return 15;
      2'd1:    return 63;
      2'd2:    return 255;
      default: return 1023;
    endcase
  endfunction

  // Behavioural model: mode/colour as integers, bounce kept as a lamp position.
  int         m_cnt, m_pat, m_mode, m_col, m_pos;
  bit         m_up;
  logic [3:0] past0, past1, past2;

  always @(posedge clock or posedge i_reset) begin
    logic [3:0] evt;
    if (i_reset) begin
      m_cnt = 0; m_pat = 1; m_mode = 0; m_col = 0; m_pos = 0; m_up = 1'b1;
      past0 = '0; past1 = '0; past2 = '0;
    end else begin
      evt = past1 & ~past2;
      if (evt[0]) begin
        m_mode = (m_mode + 1) % 4;
        m_cnt  = 0;
        m_pos  = 0;
        m_up   = 1'b1;
        case (m_mode)
          0:       m_pat = 1;
          1:       m_pat = MASK;
          2:       m_pat = 1;
          default: m_pat = 0;
        endcase
      end else if (!i_sw[0]) begin
        m_cnt = 0;
      end else if (m_cnt >= lim_of(i_sw[2:1])) begin
        m_cnt = 0;
        case (m_mode)
          0: m_pat = i_sw[3] ? ((m_pat >> 1) | ((m_pat & 1) << (N - 1)))
                             : (((m_pat << 1) | (m_pat >> (N - 1))) & MASK);
          1: m_pat = ~m_pat & MASK;
          2: begin
            m_pos = m_up ? m_pos + 1 : m_pos - 1;
            if (m_pos == N - 1) m_up = 1'b0;
            else if (m_pos == 0) m_up = 1'b1;
            m_pat = 1 << m_pos;
          end
          default: begin
            if (m_pat == MASK)  m_pat = 0;
            else if (i_sw[3])   m_pat = (m_pat >> 1) | (1 << (N - 1));
            else                m_pat = ((m_pat << 1) | 1) & MASK;
          end
        endcase
      end else begin
        m_cnt++;
      end
      if (evt[1])      m_col = 0;
      else if (evt[2]) m_col = 1;
      else if (evt[3]) m_col = 2;
      past2 = past1; past1 = past0; past0 = i_btn;
    end
  end

  always @(negedge clock) begin
    logic [3:0]   evt_now;
    logic [N-1:0] exp_led;
    bit           en, exp_tick;
    if (chk_en) begin
      evt_now  = past1 & ~past2;
      en       = i_sw[0] && !i_reset;
      exp_led  = en ? N'(m_pat) : '0;
      exp_tick = en && (m_cnt >= lim_of(i_sw[2:1])) && !evt_now[0];
      check_val("led",   32'(o_led),   32'(exp_led));
      check_val("led_r", 32'(o_led_r), (m_col == 0) ? 32'(exp_led) : 32'd0);
      check_val("led_g", 32'(o_led_g), (m_col == 1) ? 32'(exp_led) : 32'd0);
      check_val("led_b", 32'(o_led_b), (m_col == 2) ? 32'(exp_led) : 32'd0);
      check_val("mode",  32'(o_mode),  32'(m_mode));
      check_val("tick",  32'(o_tick),  32'(exp_tick));
    end
  end

  // Every driving task ends 2 time units after a rising edge.
  task automatic run(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic press(input logic [3:0] mask, input int hold);
    i_btn = mask;
    run(hold);
    i_btn = '0;
    run(4);
  endtask

  task automatic wait_tick(input int budget, output int cycles);
    bit seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clock);
      cycles++;
      if (o_tick) seen = 1'b1;
    end
    check_val("tick_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    int         c1, c2;
    logic [3:0] sw_new;
    i_reset = 1'b1; i_sw = 4'b0001; i_btn = '0;
    run(2);
    check_val("rst_led",  32'(o_led), 32'd0);
    check_val("rst_tick", 32'(o_tick), 32'd0);
    check_val("rst_mode", 32'(o_mode), 32'd0);
    check_val("rst_rgb",  32'({o_led_r, o_led_g, o_led_b}), 32'd0);
    chk_en  = 1'b1;
    i_reset = 1'b0;

    wait_tick(100, c1);
    wait_tick(100, c2);
    check_val("tick_period", 32'(c2), 32'd16);
    #2;
    run(50);

    i_sw = 4'b1001;
    run(70);

    i_sw = 4'b0111;
    run(500);
    i_sw = 4'b0001;
    @(negedge clock);
    check_val("tick_lowered", 32'(o_tick), 32'd1);
    run(1);

    press(4'b0001, 100);
    check_val("mode_after_hold", 32'(o_mode), 32'd1);
    run(40);
    press(4'b0001, 3);
    check_val("mode_bounce", 32'(o_mode), 32'd2);
    run(16 * 9);
    press(4'b0001, 2);
    run(16 * 7);

    press(4'b0100, 2);
    run(40);
    press(4'b1000, 2);
    run(40);
    press(4'b1010, 1);
    check_val("red_priority", 32'(o_led_r), 32'(o_led));

    i_sw = 4'b0000;
    run(30);
    i_sw = 4'b0001;
    run(40);

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          sw_new = 4'($urandom);
          if ($urandom_range(0, 7) != 0) sw_new[2:1] = 2'($urandom_range(0, 1));
          sw_new[0] = ($urandom_range(0, 5) != 0);
          i_sw = sw_new;
          run($urandom_range(1, 40));
        end
        3, 4, 5, 6: press(4'($urandom_range(1, 15)), $urandom_range(1, 12));
        default:    run($urandom_range(5, 80));
      endcase
    end

    i_sw = 4'b0001;
    run(4);
    while (o_mode != 2'd1) press(4'b0001, 2);
    press(4'b1000, 2);
    run(5);
    @(posedge clock);
    #1 i_reset = 1'b1;
    #1;
    check_val("async_rst_led", 32'({o_led, o_led_r, o_led_g, o_led_b}), 32'd0);
    check_val("async_rst_tick", 32'(o_tick), 32'd0);
    #1 i_reset = 1'b0;
    @(negedge clock);
    check_val("post_rst_mode", 32'(o_mode), 32'd0);
    check_val("post_rst_led", 32'(o_led), 32'd1);
    check_val("post_rst_red", 32'(o_led_r), 32'd1);
    run(40);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
